// File: rtl/booth_multiplier_4bit.sv
// Sequential radix-2 Booth multiplier: signed N x N -> signed 2N product,
// one recoding step per clock, start/busy/done handshake.
module booth_multiplier_4bit #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic [2*N-1:0] P,
    output logic           busy,
    output logic           done
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic {IDLE, CALC} state_t;

    state_t        state;
    logic [N:0]    m;
    logic [N:0]    acc;
    logic [N-1:0]  q;
    logic          q_1;
    logic [CW-1:0] count;

    logic [N:0]    sum;
    logic [N:0]    acc_nx;
    logic [N-1:0]  q_nx;

    // One extra ACC/M bit keeps -M exact when M is the most negative value.
    always_comb begin
        sum = acc;
        case ({q[0], q_1})
            2'b01:   sum = acc + m;
            2'b10:   sum = acc - m;
            default: sum = acc;
        endcase
        acc_nx = {sum[N], sum[N:1]};
        q_nx   = {sum[0], q[N-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            m     <= '0;
            acc   <= '0;
            q     <= '0;
            q_1   <= 1'b0;
            count <= '0;
            P     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        m     <= {A[N-1], A};
                        q     <= B;
                        q_1   <= 1'b0;
                        acc   <= '0;
                        count <= CW'(N);
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc   <= acc_nx;
                    q     <= q_nx;
                    q_1   <= q[0];
                    count <= count - CW'(1);
                    // Last step: publish the product from the shifted values directly.
                    if (count == CW'(1)) begin
                        P     <= {acc_nx[N-1:0], q_nx};
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_multiplier_4bit.sv
// Self-checking bench for booth_multiplier_4bit: directed table, exhaustive
// sweep, busy-start, back-to-back and mid-run reset sequences.
module tb_booth_multiplier_4bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic [7:0] P;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;
    int dones  = 0;
    logic [7:0] expq[$];
    logic [7:0] prev_p = 8'h00;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } vec_t;

    vec_t vecs[7];

    booth_multiplier_4bit #(.N(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .A    (A),
        .B    (B),
        .P    (P),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: each done pulse pops the oldest accepted request.
    always @(negedge clk) begin
        if (!rst && done) begin
            dones++;
            if (expq.size() == 0) begin
                chk("unexpected_done", 8'h01, 8'h00);
            end else begin
                logic [7:0] e;
                e = expq.pop_front();
                chk("product", P, e);
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge after the done edge.
    task automatic mul(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
        A = a; B = b; start = 1'b1;
        expq.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        A = ~a; B = ~b;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            chk("busy_during", {7'd0, busy}, 8'h01);
            chk("done_early", {7'd0, done}, 8'h00);
            chk("p_hold", P, prev_p);
        end
        @(negedge clk);
        chk("done_pulse", {7'd0, done}, 8'h01);
        chk("busy_after", {7'd0, busy}, 8'h00);
        prev_p = exp;
    endtask

    initial begin
        int d0;
        vecs[0] = '{4'd3,  4'd2,  8'h06};
        vecs[1] = '{4'hD,  4'd3,  8'hF7};
        vecs[2] = '{4'd4,  4'hC,  8'hF0};
        vecs[3] = '{4'hF,  4'hF,  8'h01};
        vecs[4] = '{4'h8,  4'h8,  8'h40};
        vecs[5] = '{4'h8,  4'd7,  8'hC8};
        vecs[6] = '{4'd0,  4'hB,  8'h00};

        rst = 1'b1; start = 1'b0; A = 4'd0; B = 4'd0;
        repeat (2) @(negedge clk);
        chk("reset_p", P, 8'h00);
        chk("reset_busy", {7'd0, busy}, 8'h00);
        chk("reset_done", {7'd0, done}, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            mul(vecs[i].a, vecs[i].b, vecs[i].p);
            @(negedge clk);
            chk("done_one_cycle", {7'd0, done}, 8'h00);
        end

        for (int ia = -8; ia < 8; ia++) begin
            for (int ib = -8; ib < 8; ib++) begin
                mul(4'(ia), 4'(ib), 8'(ia * ib));
            end
        end
        @(negedge clk);

        // start while busy is ignored, then a new start in the done cycle.
        d0 = dones;
        A = 4'd3; B = 4'd2; start = 1'b1;
        expq.push_back(8'h06);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        A = 4'd7; B = 4'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_ignored_start", {7'd0, busy}, 8'h01);
        @(negedge clk);
        @(negedge clk);
        chk("done_first", {7'd0, done}, 8'h01);
        chk("p_first", P, 8'h06);
        prev_p = 8'h06;
        A = 4'd7; B = 4'd7; start = 1'b1;
        expq.push_back(8'h31);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", {7'd0, busy}, 8'h01);
        chk("b2b_p_hold", P, 8'h06);
        repeat (3) @(negedge clk);
        @(negedge clk);
        chk("b2b_done", {7'd0, done}, 8'h01);
        chk("b2b_p", P, 8'h31);
        @(negedge clk);
        chk("done_count_b2b", 8'(dones - d0), 8'd2);
        prev_p = 8'h31;

        // Reset mid-run aborts without a done pulse.
        d0 = dones;
        A = 4'hD; B = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_p", P, 8'h00);
        chk("abort_busy", {7'd0, busy}, 8'h00);
        chk("abort_done", {7'd0, done}, 8'h00);
        rst = 1'b0;
        prev_p = 8'h00;
        repeat (6) @(negedge clk);
        chk("abort_no_done", 8'(dones - d0), 8'd0);
        chk("abort_p_hold", P, 8'h00);
        mul(4'd5, 4'hE, 8'hF6);

        repeat (3) @(negedge clk);
        chk("queue_empty", 8'(expq.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
